// File: rtl/mux_round_robin_arbiter_if.sv
// Request/grant bundle shared by the requesters and the round-robin arbiter.
// The master modport is the arbiter side; slave is the requester/resource side.
interface mux_round_robin_arbiter_if #(
   parameter int WIDTH        = 8,
   parameter int SELECT_WIDTH = 2
);
   localparam int N = 1 << SELECT_WIDTH;

   logic [N-1:0]            req;
   logic [WIDTH-1:0]        req_data [N];
   logic                    done;
   logic [N-1:0]            grant;
   logic [SELECT_WIDTH-1:0] grant_index;
   logic                    grant_valid;
   logic [WIDTH-1:0]        data_out;
   logic                    timeout;

   modport master (
      input  req, req_data, done,
      output grant, grant_index, grant_valid, data_out, timeout
   );

   modport slave (
      output req, req_data, done,
      input  grant, grant_index, grant_valid, data_out, timeout
   );
endinterface

// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter with hold timeout driving a shared WIDTH-bit mux.
//   state   | meaning
//   IDLE    | no owner; picks the next requester from the rotating pointer
//   GRANTED | owner holds the mux until done, request drop or hold timeout
module mux_round_robin_arbiter #(
   parameter int WIDTH        = 8,
   parameter int SELECT_WIDTH = 2,
   parameter int MAX_HOLD     = 8
) (
   input  logic clk,
   input  logic reset_n,
   mux_round_robin_arbiter_if.master bus
);
   localparam int N  = 1 << SELECT_WIDTH;
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t                  state;
   logic [SELECT_WIDTH-1:0] pointer;
   logic [HW-1:0]           hold_count;
   logic [SELECT_WIDTH-1:0] winner;
   logic [SELECT_WIDTH-1:0] cand;
   logic                    any_req;
   logic                    owner_req;

   // Scan from the highest offset down so the nearest set bit after pointer wins.
   always_comb begin
      winner = '0;
      cand   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = pointer + SELECT_WIDTH'(i);
         if (bus.req[cand]) winner = cand;
      end
   end

   assign any_req   = |bus.req;
   assign owner_req = bus.req[bus.grant_index];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         bus.grant       <= '0;
         bus.grant_index <= '0;
         bus.grant_valid <= 1'b0;
         bus.timeout     <= 1'b0;
         pointer         <= '0;
         hold_count      <= '0;
      end else begin
         bus.timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state           <= GRANTED;
                  bus.grant_index <= winner;
                  bus.grant       <= N'(1) << winner;
                  bus.grant_valid <= 1'b1;
                  hold_count      <= '0;
                  pointer         <= winner + SELECT_WIDTH'(1);
               end
            end
            GRANTED: begin
               if (bus.done || !owner_req || hold_count == HOLD_LAST) begin
                  state           <= IDLE;
                  bus.grant       <= '0;
                  bus.grant_valid <= 1'b0;
                  // Only a forced release flags timeout; done and owner drop take priority.
                  bus.timeout     <= !bus.done && owner_req;
               end else if (hold_count != HOLD_LAST) begin
                  hold_count <= hold_count + HW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.data_out = bus.grant_valid ? bus.req_data[bus.grant_index] : '0;
   end
endmodule
